// File: rtl/cas_sort_sched.sv
// Odd-even transposition sort scheduler: loads a frame, sorts it in place with one compare-and-swap
// per cycle, then streams it out in descending order. Optional macro SORT_EARLY_EXIT_EN ends SORT early.
module cas_sort_sched #(
    parameter int NUM_INPUTS = 4,
    parameter int WIDTH      = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_data,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_out_last,
    output logic             o_busy
);

    localparam int IDXW       = $clog2(NUM_INPUTS);
    localparam int PW         = IDXW + 1;
    localparam int EVEN_PAIRS = NUM_INPUTS / 2;
    localparam int ODD_PAIRS  = (NUM_INPUTS - 1) / 2;

    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(NUM_INPUTS - 1);
    localparam logic [IDXW-1:0] EVEN_LAST = IDXW'(EVEN_PAIRS - 1);
    localparam logic [IDXW-1:0] ODD_LAST  = IDXW'((ODD_PAIRS > 0) ? ODD_PAIRS - 1 : 0);
    localparam logic [PW-1:0]   PHASES    = PW'(NUM_INPUTS);

    typedef enum logic [1:0] {
        S_LOAD,
        S_SORT,
        S_DRAIN
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [WIDTH-1:0] r_buf [NUM_INPUTS];
    logic [IDXW-1:0]  r_wr_idx;
    logic [IDXW-1:0]  r_rd_idx;
    logic [PW-1:0]    r_phase;
    logic [IDXW-1:0]  r_pair;
    logic             r_done;

    logic             w_in_fire;
    logic             w_out_fire;
    logic [IDXW-1:0]  w_lo;
    logic [IDXW-1:0]  w_hi;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_swap;
    logic             w_last_pair;
    logic [PW-1:0]    w_next_phase;
    logic             w_final;
    logic             w_sort_end;

    assign w_in_fire  = i_in_valid && o_in_ready;
    assign w_out_fire = o_out_valid && i_out_ready;

    // Pair (lo, lo+1) for the current phase: even phases start at 0, odd phases at 1.
    assign w_lo   = IDXW'({r_pair, 1'b0}) + IDXW'(r_phase[0]);
    assign w_hi   = w_lo + IDXW'(1);
    assign w_a    = r_buf[w_lo];
    assign w_b    = r_buf[w_hi];
    assign w_swap = (w_a < w_b);

    assign w_last_pair = r_phase[0] ? (r_pair == ODD_LAST) : (r_pair == EVEN_LAST);

    // Odd phases with no pairs (only when NUM_INPUTS==2) are jumped over without spending a cycle.
    assign w_next_phase = (!r_phase[0] && (ODD_PAIRS == 0)) ? (r_phase + PW'(2)) : (r_phase + PW'(1));
    assign w_final      = w_last_pair && (w_next_phase >= PHASES);

`ifdef SORT_EARLY_EXIT_EN
    logic r_phase_swapped;
    logic r_prev_zero;
    logic w_phase_zero;

    assign w_phase_zero = !(r_phase_swapped || w_swap);
    assign w_sort_end   = w_final || (w_last_pair && w_phase_zero && r_prev_zero);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_phase_swapped <= 1'b0;
            r_prev_zero     <= 1'b0;
        end else if ((r_state == S_SORT) && !r_done) begin
            if (w_last_pair) begin
                r_phase_swapped <= 1'b0;
                r_prev_zero     <= w_phase_zero;
            end else begin
                r_phase_swapped <= r_phase_swapped || w_swap;
            end
        end else begin
            r_phase_swapped <= 1'b0;
            r_prev_zero     <= 1'b0;
        end
    end
`else
    assign w_sort_end = w_final;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_LOAD: begin
                if (w_in_fire && (r_wr_idx == LAST_IDX)) begin
                    w_next_state = S_SORT;
                end
            end
            S_SORT: begin
                if (r_done) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_out_fire && (r_rd_idx == LAST_IDX)) begin
                    w_next_state = S_LOAD;
                end
            end
            default: w_next_state = S_LOAD;
        endcase
    end

    always_comb begin
        o_in_ready  = (r_state == S_LOAD) && !i_rst;
        o_busy      = (r_state == S_SORT) || (r_state == S_DRAIN);
        o_out_valid = (r_state == S_DRAIN);
        o_out_data  = '0;
        o_out_last  = 1'b0;
        if (r_state == S_DRAIN) begin
            o_out_data = r_buf[r_rd_idx];
            o_out_last = (r_rd_idx == LAST_IDX);
        end
    end

    // After the final compare, one extra SORT cycle (r_done) hands over to DRAIN.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                r_buf[i] <= '0;
            end
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_phase  <= '0;
            r_pair   <= '0;
            r_done   <= 1'b0;
        end else begin
            unique case (r_state)
                S_LOAD: begin
                    if (w_in_fire) begin
                        r_buf[r_wr_idx] <= i_in_data;
                        r_wr_idx        <= (r_wr_idx == LAST_IDX) ? '0 : (r_wr_idx + IDXW'(1));
                    end
                end
                S_SORT: begin
                    if (r_done) begin
                        r_done  <= 1'b0;
                        r_phase <= '0;
                        r_pair  <= '0;
                    end else begin
                        if (w_swap) begin
                            r_buf[w_lo] <= w_b;
                            r_buf[w_hi] <= w_a;
                        end
                        if (w_sort_end) begin
                            r_done <= 1'b1;
                        end else if (w_last_pair) begin
                            r_phase <= w_next_phase;
                            r_pair  <= '0;
                        end else begin
                            r_pair <= r_pair + IDXW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_out_fire) begin
                        r_rd_idx <= (r_rd_idx == LAST_IDX) ? '0 : (r_rd_idx + IDXW'(1));
                    end
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cas_sort_sched.sv
// Scoreboard bench for cas_sort_sched: driver loads frames, monitor pops expected words
// and latencies as the sorted frame streams out.
module tb_cas_sort_sched;

    localparam int N = 4;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out_ready = 1'b0;
    logic         o_in_ready;
    logic         o_out_valid;
    logic [W-1:0] o_out_data;
    logic         o_out_last;
    logic         o_busy;

    typedef struct {
        logic [W-1:0] d;
        logic         l;
    } exp_t;

    exp_t expQ[$];
    int   latQ[$];
    int   cyc = 0;
    int   lastT = 0;
    int   stallCycles = 0;
    int   errors = 0;
    int   checks = 0;

    cas_sort_sched #(.NUM_INPUTS(N), .WIDTH(W)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_in_valid (in_valid),
        .o_in_ready (o_in_ready),
        .i_in_data  (in_data),
        .o_out_valid(o_out_valid),
        .i_out_ready(out_ready),
        .o_out_data (o_out_data),
        .o_out_last (o_out_last),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Edges from last input handshake to out_valid: one handover cycle plus one cycle per executed compare.
    function automatic int modelLatency(input logic [W-1:0] w[N]);
        int a[N];
        int cnt;
        int tmp;
        int swaps;
`ifdef SORT_EARLY_EXIT_EN
        int prevZero;
        prevZero = 0;
`endif
        cnt = 0;
        for (int i = 0; i < N; i++) a[i] = int'(w[i]);
        for (int p = 0; p < N; p++) begin
            swaps = 0;
            if ((p % 2) + 1 >= N) continue;
            for (int i = p % 2; i + 1 < N; i += 2) begin
                cnt++;
                if (a[i] < a[i+1]) begin
                    tmp = a[i]; a[i] = a[i+1]; a[i+1] = tmp;
                    swaps++;
                end
            end
`ifdef SORT_EARLY_EXIT_EN
            if (swaps == 0 && prevZero != 0) return cnt + 1;
            prevZero = (swaps == 0) ? 1 : 0;
`endif
        end
        return cnt + 1;
    endfunction

    task automatic applyStimulus(input logic [W-1:0] w[N], input int gap, input int junk);
        int t;
        exp_t e;
        int k;
        for (int i = 0; i < N; i++) begin
            repeat (gap) @(negedge clk);
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = w[i];
            t = 0;
            while (!o_in_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) checkOutput("load_timeout", 1, 0);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (i == N - 1) lastT = cyc;
        end
        k = 0;
        for (int v = (1 << W) - 1; v >= 0; v--) begin
            for (int i = 0; i < N; i++) begin
                if (int'(w[i]) == v) begin
                    e.d = W'(v);
                    e.l = (k == N - 1);
                    expQ.push_back(e);
                    k++;
                end
            end
        end
        latQ.push_back(modelLatency(w));
        if (junk != 0) begin
            repeat (3) begin
                @(negedge clk);
                in_valid = 1'b1;
                in_data  = W'($urandom);
            end
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic waitDrain();
        int t;
        t = 0;
        while ((expQ.size() != 0 || latQ.size() != 0 || o_out_valid) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) checkOutput("drain_timeout", 1, 0);
    endtask

    // Monitor: drives out_ready, checks latency, hold-while-stalled and popped words.
    initial begin
        logic         seen;
        logic         prevStall;
        logic [W-1:0] prevData;
        logic         prevLast;
        logic         rdy;
        exp_t         e;
        seen      = 1'b0;
        prevStall = 1'b0;
        prevData  = '0;
        prevLast  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen      = 1'b0;
                prevStall = 1'b0;
                out_ready = 1'b0;
            end else begin
                if (prevStall) begin
                    checkOutput("stall_valid", 32'(o_out_valid), 1);
                    checkOutput("stall_data", 32'(o_out_data), 32'(prevData));
                    checkOutput("stall_last", 32'(o_out_last), 32'(prevLast));
                end
                if (o_out_valid && !seen) begin
                    seen = 1'b1;
                    if (latQ.size() == 0) checkOutput("unexpected_valid", 1, 0);
                    else checkOutput("latency", 32'(cyc - lastT), 32'(latQ.pop_front()));
                end
                if (stallCycles > 0 && o_out_valid) begin
                    rdy = 1'b0;
                    stallCycles--;
                end else begin
                    rdy = ($urandom_range(0, 3) != 0);
                end
                out_ready = rdy;
                if (o_out_valid && rdy) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_out", 1, 0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("out_data", 32'(o_out_data), 32'(e.d));
                        checkOutput("out_last", 32'(o_out_last), 32'(e.l));
                        if (e.l) seen = 1'b0;
                    end
                end
                prevStall = o_out_valid && !rdy;
                prevData  = o_out_data;
                prevLast  = o_out_last;
            end
        end
    end

    initial begin
        logic [W-1:0] f[N];
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(o_in_ready), 0);
        checkOutput("rst_out_valid", 32'(o_out_valid), 0);
        checkOutput("rst_out_last", 32'(o_out_last), 0);
        checkOutput("rst_busy", 32'(o_busy), 0);
        checkOutput("rst_out_data", 32'(o_out_data), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("in_ready_after_rst", 32'(o_in_ready), 1);

        f = '{3'd1, 3'd5, 3'd3, 3'd7};
        applyStimulus(f, 0, 0);
        waitDrain();

        f = '{3'd0, 3'd1, 3'd2, 3'd3};
        applyStimulus(f, 2, 1);
        waitDrain();

        f = '{3'd2, 3'd2, 3'd2, 3'd2};
        applyStimulus(f, 0, 0);
        waitDrain();

        stallCycles = 3;
        f = '{3'd6, 3'd1, 3'd7, 3'd2};
        applyStimulus(f, 0, 0);
        waitDrain();

        f = '{3'd7, 3'd6, 3'd5, 3'd4};
        applyStimulus(f, 1, 1);
        waitDrain();

        f = '{3'd1, 3'd2, 3'd3, 3'd0};
        applyStimulus(f, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        expQ.delete();
        latQ.delete();
        #1;
        checkOutput("midrst_out_valid", 32'(o_out_valid), 0);
        checkOutput("midrst_busy", 32'(o_busy), 0);
        checkOutput("midrst_in_ready", 32'(o_in_ready), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("postrst_in_ready", 32'(o_in_ready), 1);
        checkOutput("postrst_busy", 32'(o_busy), 0);
        f = '{3'd4, 3'd0, 3'd6, 3'd1};
        applyStimulus(f, 0, 0);
        waitDrain();

        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < N; i++) f[i] = W'($urandom);
            if ($urandom_range(0, 4) == 0) stallCycles = $urandom_range(1, 4);
            applyStimulus(f, $urandom_range(0, 2), $urandom_range(0, 1));
            waitDrain();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
